// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RISC-V pipeline: forwarding, load-use,
// mispredict redirect and data-memory wait freeze. Define PERF_CNT_EN for perf counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic [4:0]       rdM,
    input  logic             RegWriteW,
    input  logic [4:0]       rdW,
    input  logic             MemReqM,
    input  logic             dmem_ready,
    input  logic             BranchE,
    input  logic             JumpE,
    input  logic             TakenE,
    input  logic             PredTakenE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             redirect,
    output logic             mem_err,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q, mem_err_d;

    logic       lw, mis, freeze;

    // Forwarding for both EX operands; x0 never matches, MEM wins over WB.
    logic [1:0][4:0] rs_e;
    logic [1:0][1:0] fwd_sel;
    assign rs_e[0] = rs1E;
    assign rs_e[1] = rs2E;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] = (RegWriteM && rdM != 5'd0 && rdM == rs_e[gi]) ? 2'b10 :
                                 (RegWriteW && rdW != 5'd0 && rdW == rs_e[gi]) ? 2'b01 :
                                                                                2'b00;
        end
    endgenerate

    assign ForwardAE = fwd_sel[0];
    assign ForwardBE = fwd_sel[1];

    assign lw     = (ResultSrcE == 2'b01) && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
    assign mis    = (BranchE && (TakenE ^ PredTakenE)) || (JumpE && !PredTakenE);
    assign freeze = ((state_q == RUN) && MemReqM && !dmem_ready) ||
                    ((state_q == MEM_WAIT) && !dmem_ready && (wait_cnt_q < TMO_LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            RUN: begin
                if (MemReqM && !dmem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == TMO_LAST) begin
                    // Give up on the access: release the pipeline and latch the error.
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                    mem_err_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = 8'd0;
            end
        endcase
    end

    // A mispredict seen during a freeze simply stays in EX until the freeze ends.
    always_comb begin
        StallF   = 1'b0;
        StallD   = 1'b0;
        StallE   = 1'b0;
        StallM   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        redirect = 1'b0;
        if (reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (freeze) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
        end else if (mis) begin
            redirect = 1'b1;
            FlushD   = 1'b1;
            FlushE   = 1'b1;
        end else if (lw) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
    end

    assign mem_err = mem_err_q;

`ifdef PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             any_stall;

    assign any_stall = StallF || StallD || StallE || StallM;

    always_comb begin
        br_cnt_d      = br_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        if (!freeze) begin
            if ((BranchE || JumpE) && br_cnt_q != '1)
                br_cnt_d = br_cnt_q + CNT_ONE;
            if (mis && mispred_cnt_q != '1)
                mispred_cnt_d = mispred_cnt_q + CNT_ONE;
        end
        // Stall cycles include freeze cycles, so this one ignores the freeze gate.
        if (any_stall && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign br_cnt      = br_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
    assign stall_cnt   = stall_cnt_q;
`else
    assign br_cnt      = '0;
    assign mispred_cnt = '0;
    assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a vector table for the combinational paths plus
// hand sequences for memory wait, timeout and reset; counters checked when PERF_CNT_EN is set.
module tb_pipe_hazard_ctrl;

    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic [1:0]    ResultSrcE;
    logic          RegWriteM, RegWriteW, MemReqM, dmem_ready;
    logic          BranchE, JumpE, TakenE, PredTakenE;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, redirect, mem_err;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [CW-1:0] br_cnt, mispred_cnt, stall_cnt;
    logic [6:0]    ctl;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, redirect};

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .rdM(rdM),
        .RegWriteW(RegWriteW), .rdW(rdW), .MemReqM(MemReqM), .dmem_ready(dmem_ready),
        .BranchE(BranchE), .JumpE(JumpE), .TakenE(TakenE), .PredTakenE(PredTakenE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .redirect(redirect), .mem_err(mem_err),
        .br_cnt(br_cnt), .mispred_cnt(mispred_cnt), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE;
        logic [1:0] rsrc;
        logic       rwM;
        logic [4:0] rdM;
        logic       rwW;
        logic [4:0] rdW;
        logic       br, jmp, tk, pt;
        logic [1:0] fa, fb;
        logic [6:0] ctl;   // {StallF,StallD,StallE,StallM,FlushD,FlushE,redirect}
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_cnt(input string name, input int b, input int m, input int s);
`ifdef PERF_CNT_EN
        check({name, "_br_cnt"}, 64'(br_cnt), 64'(b));
        check({name, "_mispred_cnt"}, 64'(mispred_cnt), 64'(m));
        check({name, "_stall_cnt"}, 64'(stall_cnt), 64'(s));
`else
        check({name, "_br_cnt"}, 64'(br_cnt), 64'(b * 0));
        check({name, "_mispred_cnt"}, 64'(mispred_cnt), 64'(m * 0));
        check({name, "_stall_cnt"}, 64'(stall_cnt), 64'(s * 0));
`endif
    endtask

    task automatic idle_inputs();
        rs1D = 5'd0; rs2D = 5'd0; rs1E = 5'd0; rs2E = 5'd0; rdE = 5'd0;
        ResultSrcE = 2'b00; RegWriteM = 1'b0; rdM = 5'd0; RegWriteW = 1'b0; rdW = 5'd0;
        MemReqM = 1'b0; dmem_ready = 1'b1;
        BranchE = 1'b0; JumpE = 1'b0; TakenE = 1'b0; PredTakenE = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        #1 check("reset_ctl", 64'(ctl), 64'(7'b0000110));
        tick();
        check("reset_mem_err", 64'(mem_err), 64'd0);
        check_cnt("reset", 0, 0, 0);
        reset = 1'b0;
    endtask

    initial begin
        //                rs1D   rs2D   rs1E   rs2E   rdE    rsrc   rwM   rdM    rwW   rdW    br    jmp   tk    pt    fa     fb     ctl
        vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 7'b0000000};
        vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b1, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 7'b0000000};
        vecs[2]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 2'b00, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 7'b0000000};
        vecs[3]  = '{5'd0, 5'd0, 5'd5, 5'd9, 5'd0, 2'b00, 1'b0, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 7'b0000000};
        vecs[4]  = '{5'd0, 5'd0, 5'd9, 5'd9, 5'd0, 2'b00, 1'b1, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 7'b0000000};
        vecs[5]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 7'b0000000};
        vecs[6]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 7'b1100010};
        vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 7'b0000000};
        vecs[8]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 7'b0000000};
        vecs[9]  = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 7'b1100010};
        vecs[10] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 7'b0000111};
        vecs[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 7'b0000000};
        vecs[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 7'b0000111};
        vecs[13] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 7'b0000000};
        vecs[14] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 7'b0000111};
        vecs[15] = '{5'd0, 5'd0, 5'd5, 5'd5, 5'd0, 2'b00, 1'b0, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 7'b0000000};

        do_reset();

        // Vector table: one vector per clock, counters accumulate across it.
        for (int i = 0; i < NV; i++) begin
            rs1D = vecs[i].rs1D; rs2D = vecs[i].rs2D; rs1E = vecs[i].rs1E; rs2E = vecs[i].rs2E;
            rdE = vecs[i].rdE; ResultSrcE = vecs[i].rsrc; RegWriteM = vecs[i].rwM; rdM = vecs[i].rdM;
            RegWriteW = vecs[i].rwW; rdW = vecs[i].rdW; BranchE = vecs[i].br; JumpE = vecs[i].jmp;
            TakenE = vecs[i].tk; PredTakenE = vecs[i].pt;
            #1;
            $display("vec %0d: fa=%b fb=%b ctl=%b", i, ForwardAE, ForwardBE, ctl);
            check($sformatf("vec%0d_fwdA", i), 64'(ForwardAE), 64'(vecs[i].fa));
            check($sformatf("vec%0d_fwdB", i), 64'(ForwardBE), 64'(vecs[i].fb));
            check($sformatf("vec%0d_ctl", i), 64'(ctl), 64'(vecs[i].ctl));
            tick();
        end
        idle_inputs();
        #1;
        // 5 branch/jumps saturate the 2-bit counter at 3; 3 mispredicts; 2 load-use stalls.
        check_cnt("table", 3, 3, 2);

        // Load-use: exactly one bubble, then clean.
        do_reset();
        ResultSrcE = 2'b01; rdE = 5'd7; rs2D = 5'd7;
        #1 check("lu_c0_ctl", 64'(ctl), 64'(7'b1100010));
        tick();
        rdE = 5'd0;
        #1 check("lu_c1_ctl", 64'(ctl), 64'(7'b0000000));
        check_cnt("lu", 0, 0, 1);
        $display("seq load_use done");

        // Memory wait 3 cycles with a mispredict pending in EX.
        do_reset();
        MemReqM = 1'b1; dmem_ready = 1'b0; BranchE = 1'b1; TakenE = 1'b1; PredTakenE = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("memw_c%0d_ctl", k), 64'(ctl), 64'(7'b1111000));
            tick();
        end
        dmem_ready = 1'b1;
        #1 check("memw_release_ctl", 64'(ctl), 64'(7'b0000111));
        tick();
        idle_inputs();
        #1 check("memw_after_ctl", 64'(ctl), 64'(7'b0000000));
        check("memw_mem_err", 64'(mem_err), 64'd0);
        check_cnt("memw", 1, 1, 3);
        MemReqM = 1'b1; dmem_ready = 1'b1;
        #1 check("memw_ready_same_cycle_ctl", 64'(ctl), 64'(7'b0000000));
        tick();
        idle_inputs();
        $display("seq mem_wait done");

        // Timeout with MEM_TIMEOUT=4: three freeze cycles, then release and sticky error.
        do_reset();
        MemReqM = 1'b1; dmem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("tmo_c%0d_ctl", k), 64'(ctl), 64'(7'b1111000));
            check($sformatf("tmo_c%0d_mem_err", k), 64'(mem_err), 64'd0);
            tick();
        end
        MemReqM = 1'b0;
        #1 check("tmo_release_ctl", 64'(ctl), 64'(7'b0000000));
        tick();
        #1 check("tmo_mem_err_set", 64'(mem_err), 64'd1);
        check("tmo_after_ctl", 64'(ctl), 64'(7'b0000000));
        tick();
        tick();
        check("tmo_mem_err_sticky", 64'(mem_err), 64'd1);
        check_cnt("tmo", 0, 0, 3);
        $display("seq timeout done");

        // Reset while in MEM_WAIT (mem_err still set from the timeout).
        MemReqM = 1'b1; dmem_ready = 1'b0;
        #1 check("rmw_c0_ctl", 64'(ctl), 64'(7'b1111000));
        tick();
        #1 check("rmw_c1_ctl", 64'(ctl), 64'(7'b1111000));
        reset = 1'b1;
        #1 check("rmw_rst_ctl", 64'(ctl), 64'(7'b0000110));
        tick();
        #1 check("rmw_rst_held_ctl", 64'(ctl), 64'(7'b0000110));
        check("rmw_mem_err_clr", 64'(mem_err), 64'd0);
        check_cnt("rmw", 0, 0, 0);
        reset = 1'b0; MemReqM = 1'b0;
        #1 check("rmw_run_ctl", 64'(ctl), 64'(7'b0000000));
        tick();
        $display("seq reset_mid_wait done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
